// File: rtl/guess_arbiter.sv
// guess_arbiter: round-robin arbiter sharing one Game_logic guess port; filters illegal/duplicate letters.
// Optional WAIT timeout enabled by defining GUESS_ARB_TIMEOUT_EN.
module guess_arbiter #(
  parameter int NUM_PLAYERS    = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                     clk,
  input  logic                     nRst,
  input  logic [NUM_PLAYERS-1:0]   req,
  input  logic [8*NUM_PLAYERS-1:0] guess_in,
  input  logic                     game_rdy,
  input  logic                     result_done,
  input  logic                     game_over,
  input  logic                     new_round,
  output logic [7:0]               guess,
  output logic                     guess_stb,
  output logic [NUM_PLAYERS-1:0]   ack,
  output logic [1:0]               status,
  output logic [25:0]              guessed_map
);
  localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
  typedef enum logic [2:0] {IDLE, CHECK, ISSUE, WAIT, ACK, STOP} state_t;
  state_t          r_state, w_next;
  logic [PW-1:0]   r_rr, r_grant, w_pick;
  logic [7:0]      r_letter;
  logic [1:0]      r_code, w_code;
  logic            w_found, w_legal, w_timeout, w_grant, w_issue, w_ack;
  logic [4:0]      w_idx;
  int              w_pos;
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_pos   = 0;
    for (int k = NUM_PLAYERS - 1; k >= 0; k--) begin
      w_pos = (int'(r_rr) + k) % NUM_PLAYERS;
      if (req[w_pos]) begin
        w_found = 1'b1;
        w_pick  = PW'(w_pos);
      end
    end
  end
  assign w_legal = (r_letter >= 8'h41) && (r_letter <= 8'h5A);
  assign w_idx   = 5'(r_letter - 8'h41);
`ifdef GUESS_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_timer;
  always_ff @(posedge clk) begin
    if (!nRst || new_round || r_state != WAIT) r_timer <= '0;
    else r_timer <= r_timer + 1'b1;
  end
  assign w_timeout = (r_state == WAIT) && (r_timer == TW'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif
  always_comb begin
    w_next = r_state;
    w_code = r_code;
    if (new_round) w_next = IDLE;
    else if (game_over && r_state inside {CHECK, ISSUE, WAIT}) begin
      w_next = ACK;
      w_code = 2'b11;
    end else begin
      case (r_state)
        IDLE:  w_next = game_over ? STOP : (game_rdy && w_found) ? CHECK : IDLE;
        CHECK: begin
          w_next = (!w_legal || guessed_map[w_idx]) ? ACK : ISSUE;
          w_code = !w_legal ? 2'b10 : guessed_map[w_idx] ? 2'b01 : 2'b00;
        end
        ISSUE: w_next = WAIT;
        WAIT: begin
          w_next = (result_done || w_timeout) ? ACK : WAIT;
          w_code = result_done ? 2'b00 : 2'b11;
        end
        ACK:     w_next = game_over ? STOP : IDLE;
        STOP:    w_next = STOP;
        default: w_next = IDLE;
      endcase
    end
  end
  assign w_grant = (r_state == IDLE) && (w_next == CHECK);
  assign w_issue = (r_state == ISSUE) && (w_next == WAIT);
  assign w_ack   = (r_state == ACK) && !new_round;
  // Outputs are registered: each appears one cycle after the state that produces it.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      r_state     <= IDLE;
      r_code      <= 2'b00;
      r_rr        <= '0;
      r_grant     <= '0;
      r_letter    <= 8'h00;
      guess       <= 8'h00;
      guess_stb   <= 1'b0;
      ack         <= '0;
      status      <= 2'b00;
      guessed_map <= '0;
    end else begin
      r_state   <= w_next;
      r_code    <= w_code;
      guess_stb <= w_issue;
      ack       <= w_ack ? NUM_PLAYERS'(1) << r_grant : '0;
      if (w_ack) status <= r_code;
      if (w_grant) begin
        r_grant  <= w_pick;
        r_letter <= guess_in[{w_pick, 3'b000} +: 8];
        r_rr     <= (w_pick == PW'(NUM_PLAYERS - 1)) ? '0 : w_pick + 1'b1;
      end
      if (w_issue) begin
        guess              <= r_letter;
        guessed_map[w_idx] <= 1'b1;
      end
      if (new_round) guessed_map <= '0;
    end
  end
endmodule

// File: tb/tb_guess_arbiter.sv
// tb_guess_arbiter: randomized self-checking bench with a turn-level reference model.
module tb_guess_arbiter;
  localparam int TMO = 8;
  logic        clk = 1'b0;
  logic        nRst;
  logic [3:0]  req;
  logic [31:0] guess_in;
  logic        game_rdy, result_done, game_over, new_round;
  logic [7:0]  guess;
  logic        guess_stb;
  logic [3:0]  ack;
  logic [1:0]  status;
  logic [25:0] guessed_map;
  int          n_checks = 0;
  int          n_fail = 0;
  int          rr = 0;
  logic [25:0] gmap = '0;
  guess_arbiter #(.NUM_PLAYERS(4), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .nRst(nRst), .req(req), .guess_in(guess_in), .game_rdy(game_rdy),
    .result_done(result_done), .game_over(game_over), .new_round(new_round),
    .guess(guess), .guess_stb(guess_stb), .ack(ack), .status(status),
    .guessed_map(guessed_map)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  // One full turn from IDLE. mode 0: result_done d cycles after strobe; 1: game_over abort; 2: timeout.
  task automatic turn(input logic [3:0] rq, input logic [31:0] lt, input int d, input int mode);
    int w, last;
    logic [7:0] l;
    logic [1:0] st;
    bit acc;
    w = -1;
    for (int k = 0; k < 4; k++) if (w < 0 && rq[(rr + k) % 4]) w = (rr + k) % 4;
    rr = (w + 1) % 4;
    l = lt[8*w +: 8];
    st = (l < 8'h41 || l > 8'h5A) ? 2'd2 : gmap[l - 8'h41] ? 2'd1 : 2'd0;
    acc = (st == 2'd0);
    if (acc) begin
      gmap[l - 8'h41] = 1'b1;
      st = (mode == 0) ? 2'd0 : 2'd3;
    end
    // Strobe appears 3 cycles after grant; ack 2 cycles after the terminating event.
    last = !acc ? 3 : (mode == 2) ? 4 + TMO : 5 + d;
    req = rq;
    guess_in = lt;
    game_rdy = 1'b1;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      check("strobe", 32'(guess_stb), 32'(acc && c == 3));
      if (acc && c == 3) check("guess", 32'(guess), 32'(l));
      check("ack", 32'(ack), c == last ? 32'(1 << w) : 32'd0);
      if (c == last) check("status", 32'(status), 32'(st));
      result_done = acc && mode == 0 && c == 3 + d;
      if (acc && mode == 1 && c == 3 + d) game_over = 1'b1;
    end
    req = 4'h0;
    result_done = 1'b0;
    check("map", 32'(guessed_map), 32'(gmap));
  endtask
  task automatic quiet(input string tag, input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      check(tag, {27'd0, ack, guess_stb}, 32'd0);
    end
  endtask
  initial begin
    nRst = 1'b0; req = 4'hF; guess_in = "ZYXW"; game_rdy = 1'b1;
    result_done = 1'b0; game_over = 1'b0; new_round = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_guess", 32'(guess), 32'd0);
    check("rst_stb", 32'(guess_stb), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_status", 32'(status), 32'd0);
    check("rst_map", 32'(guessed_map), 32'd0);
    nRst = 1'b1;
    for (int i = 0; i < 4; i++) turn(4'hF, "DCBA", 2, 0);
    turn(4'b0010, "xxPx", 1, 0);
    turn(4'b0100, "xPxx", 1, 0);
    turn(4'b0001, {24'h0, 8'h61}, 0, 0);
    turn(4'b0001, {24'h0, 8'h40}, 0, 0);
    turn(4'b0010, {16'h0, 8'h5B, 8'h0}, 0, 0);
    turn(4'b0100, "xZxx", 0, 0);
    req = 4'b1000; guess_in = "Hxxx"; game_rdy = 1'b0;
    quiet("not_ready", 5);
    turn(4'b1000, "Hxxx", 3, 0);
`ifdef GUESS_ARB_TIMEOUT_EN
    turn(4'b0001, "xxxT", 0, 2);
`else
    turn(4'b0001, "xxxT", 200, 0);
`endif
    turn(4'b0001, "xxxQ", 1, 1);
    req = 4'hF; guess_in = "MNOR";
    quiet("stop", 10);
    req = 4'h0; game_over = 1'b0; new_round = 1'b1;
    @(negedge clk);
    new_round = 1'b0;
    gmap = '0;
    check("nr_map", 32'(guessed_map), 32'd0);
    turn(4'b0010, "xxQx", 0, 0);
    req = 4'b0100; guess_in = "xKxx";
    @(negedge clk);
    req = 4'h0; new_round = 1'b1;
    @(negedge clk);
    new_round = 1'b0;
    rr = 3;
    gmap = '0;
    quiet("dropped", 6);
    check("drop_map", 32'(guessed_map), 32'd0);
    for (int i = 0; i < 40; i++) begin
      logic [31:0] lt;
      logic [3:0] rq;
      for (int b = 0; b < 4; b++)
        lt[8*b +: 8] = ($urandom % 5 == 0) ? 8'($urandom) : 8'(8'h41 + $urandom % 26);
      rq = 4'($urandom_range(1, 15));
      turn(rq, lt, int'($urandom % 4), 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
